spi_xfer_ctrl: RTL and testbench

// Transfer sequencer for the SPI master: owns one character transfer from go to done. Drives tip/lstclk

---
 rtl/spi_xfer_ctrl.sv | 133 +++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: one character from go to done.
// Drives tip/lstclk into spi_clgen and turns its edge strobes into shift/sample enables.
module spi_xfer_ctrl #(
    parameter int CHAR_LEN_BITS = 7,
    parameter int SS_NB         = 8
) (
    input  logic                     wb_clk,
    input  logic                     wb_reset_n,
    input  logic                     go,
    input  logic                     abort,
    input  logic [CHAR_LEN_BITS-1:0] char_len,
    input  logic                     tx_negedge,
    input  logic                     rx_negedge,
    input  logic                     ass,
    input  logic [SS_NB-1:0]         ss_sel,
    input  logic                     ie,
    input  logic                     irq_clr,
    input  logic                     cpol_0,
    input  logic                     cpol_1,
    output logic                     tip,
    output logic                     lstclk,
    output logic                     shift_en,
    output logic                     sample_en,
    output logic [CHAR_LEN_BITS:0]   bit_cnt,
    output logic [SS_NB-1:0]         ss_pad_o,
    output logic                     busy,
    output logic                     done,
    output logic                     irq
);

    localparam int CW = CHAR_LEN_BITS + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             tx_neg_q, tx_neg_d;
    logic             rx_neg_q, rx_neg_d;
    logic             irq_q, irq_d;
    logic [SS_NB-1:0] ss_q, ss_d;

    logic in_xfer;
    logic in_done;

    assign in_xfer = (state_q == ST_XFER);
    assign in_done = (state_q == ST_DONE);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_neg_d  = tx_neg_q;
        rx_neg_d  = rx_neg_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    // a zero length field means the full 2**CHAR_LEN_BITS bits
                    bit_cnt_d = {(char_len == '0), char_len};
                    tx_neg_d  = tx_negedge;
                    rx_neg_d  = rx_negedge;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else if (cpol_1) begin
                    bit_cnt_d = bit_cnt_q - CW'(1);
                    if (bit_cnt_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        irq_d = (in_done & ie) | (irq_q & ~irq_clr);
        // selects are registered off the next state so pads change glitch-free
        if (!ass || (state_d != ST_IDLE)) begin
            ss_d = ~ss_sel;
        end else begin
            ss_d = '1;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            tx_neg_q  <= 1'b0;
            rx_neg_q  <= 1'b0;
            irq_q     <= 1'b0;
            ss_q      <= '1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_neg_q  <= tx_neg_d;
            rx_neg_q  <= rx_neg_d;
            irq_q     <= irq_d;
            ss_q      <= ss_d;
        end
    end

    assign tip       = in_xfer;
    assign lstclk    = in_xfer & (bit_cnt_q == CW'(1));
    assign shift_en  = in_xfer & (tx_neg_q ? cpol_1 : cpol_0);
    assign sample_en = in_xfer & (rx_neg_q ? cpol_1 : cpol_0);
    assign bit_cnt   = bit_cnt_q;
    assign ss_pad_o  = ss_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = in_done;
    assign irq       = irq_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: table of transfer configurations, a clgen strobe model,
// a scoreboard of expected per-transfer counts, plus reset/abort/irq sequences.
module tb_spi_xfer_ctrl;

    logic       clk;
    logic       rst_n;
    logic       go;
    logic       abort;
    logic [6:0] char_len;
    logic       tx_negedge;
    logic       rx_negedge;
    logic       ass;
    logic [7:0] ss_sel;
    logic       ie;
    logic       irq_clr;
    logic       cpol_0;
    logic       cpol_1;
    logic       tip;
    logic       lstclk;
    logic       shift_en;
    logic       sample_en;
    logic [7:0] bit_cnt;
    logic [7:0] ss_pad_o;
    logic       busy;
    logic       done;
    logic       irq;

    spi_xfer_ctrl #(.CHAR_LEN_BITS(7), .SS_NB(8)) dut (
        .wb_clk     (clk),
        .wb_reset_n (rst_n),
        .go         (go),
        .abort      (abort),
        .char_len   (char_len),
        .tx_negedge (tx_negedge),
        .rx_negedge (rx_negedge),
        .ass        (ass),
        .ss_sel     (ss_sel),
        .ie         (ie),
        .irq_clr    (irq_clr),
        .cpol_0     (cpol_0),
        .cpol_1     (cpol_1),
        .tip        (tip),
        .lstclk     (lstclk),
        .shift_en   (shift_en),
        .sample_en  (sample_en),
        .bit_cnt    (bit_cnt),
        .ss_pad_o   (ss_pad_o),
        .busy       (busy),
        .done       (done),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] cl;
        logic       tx;
        logic       rx;
        logic       asel;
        logic [7:0] ss;
        logic       ie;
        logic       pre_clr;
        logic       clr_hold;
        int         go_at;
        int         ab_bits;
        logic [7:0] exp_ss;
        logic       exp_irq;
    } vec_t;

    typedef struct {
        int         bits;
        int         sh_f;
        int         sh_r;
        int         sa_f;
        int         sa_r;
        int         lst;
        logic [7:0] ss;
    } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic [6:0] cl, input logic tx, input logic rx,
        input logic asel, input logic [7:0] ss, input logic ie,
        input logic pre_clr, input logic clr_hold, input int go_at,
        input int ab_bits, input logic [7:0] exp_ss,
        input logic exp_irq);
        vec_t v;
        v.cl = cl; v.tx = tx; v.rx = rx; v.asel = asel; v.ss = ss;
        v.ie = ie; v.pre_clr = pre_clr; v.clr_hold = clr_hold;
        v.go_at = go_at; v.ab_bits = ab_bits;
        v.exp_ss = exp_ss; v.exp_irq = exp_irq;
        return v;
    endfunction

    task automatic run(input vec_t v);
        exp_t       e;
        exp_t       g;
        int         n;
        int         obs_bits;
        int         last_fall_k;
        int         done_lat;
        int         ss_bad;
        int         n_done;
        bit         got_done;
        bit         aborted;
        logic [7:0] ss_after;
        cpol_0 = 0; cpol_1 = 0; abort = 0; go = 0; irq_clr = 0;
        tx_negedge = v.tx; rx_negedge = v.rx; ass = v.asel;
        ss_sel = v.ss; ie = v.ie;
        if (v.pre_clr) begin
            irq_clr = 1;
            settle();
            adv();
            irq_clr = 0;
            settle();
            chk("irq_clr_alone", irq, 0);
            adv();
        end
        char_len = v.cl;
        go = 1;
        settle();
        chk("idle_busy", busy, 0);
        adv();
        n = (v.cl == 0) ? 128 : int'(v.cl);
        if (v.ab_bits < 0) begin
            e.bits = n;
            e.sh_f = v.tx ? n : 0;
            e.sh_r = v.tx ? 0 : n;
            e.sa_f = v.rx ? n : 0;
            e.sa_r = v.rx ? 0 : n;
            e.lst  = (n == 1) ? 3 : 4;
            e.ss   = v.exp_ss;
            sb.push_back(e);
        end
        go = 0;
        char_len = v.cl ^ 7'h55;
        cpol_0 = 1; cpol_1 = 1;
        settle();
        chk("setup_tip", tip, 0);
        chk("setup_ss", ss_pad_o, v.exp_ss);
        chk("setup_shift", shift_en, 0);
        chk("setup_cnt", bit_cnt, n);
        adv();
        g = '{default: 0};
        obs_bits = 0; last_fall_k = -10; done_lat = -1; ss_bad = 0;
        got_done = 0; aborted = 0;
        for (int k = 0; k < 1000; k++) begin
            cpol_0 = (k % 4 == 0);
            cpol_1 = (k % 4 == 2);
            go = (k == v.go_at);
            char_len = (k == v.go_at) ? 7'd3 : v.cl;
            abort = (v.ab_bits >= 0) && (obs_bits == v.ab_bits);
            irq_clr = v.clr_hold;
            settle();
            if (k == 0) begin
                chk("xfer_tip", tip, 1);
                chk("xfer_cnt0", bit_cnt, n);
            end
            if (shift_en) begin
                if (cpol_1) g.sh_f++; else g.sh_r++;
            end
            if (sample_en) begin
                if (cpol_1) g.sa_f++; else g.sa_r++;
            end
            if (lstclk) g.lst++;
            if (tip && ss_pad_o !== v.exp_ss) ss_bad++;
            if (tip && cpol_1) begin
                obs_bits++;
                last_fall_k = k;
            end
            if (done) begin
                got_done = 1;
                done_lat = k - last_fall_k;
            end
            if (abort) aborted = 1;
            adv();
            if (got_done || aborted) break;
        end
        go = 0; abort = 0; cpol_0 = 0; cpol_1 = 0; irq_clr = 0;
        char_len = v.cl;
        if (!got_done && !aborted) chk("xfer_timeout", 0, 1);
        if (got_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("bits", obs_bits, e.bits);
                chk("shift_fall", g.sh_f, e.sh_f);
                chk("shift_rise", g.sh_r, e.sh_r);
                chk("sample_fall", g.sa_f, e.sa_f);
                chk("sample_rise", g.sa_r, e.sa_r);
                chk("lstclk_cycles", g.lst, e.lst);
                chk("done_latency", done_lat, 1);
                chk("ss_during", ss_bad, 0);
            end
            ss_after = v.asel ? 8'hFF : ~v.ss;
            settle();
            chk("done_pulse", done, 0);
            chk("post_busy", busy, 0);
            chk("post_ss", ss_pad_o, ss_after);
            chk("post_irq", irq, v.exp_irq);
            adv();
        end
        if (aborted) begin
            settle();
            chk("abort_tip", tip, 0);
            chk("abort_cnt", bit_cnt, 0);
            chk("abort_lstclk", lstclk, 0);
            chk("abort_busy", busy, 0);
            chk("abort_ss", ss_pad_o, 8'hFF);
            chk("abort_bits", obs_bits, v.ab_bits);
            adv();
            n_done = 0;
            for (int k = 0; k < 8; k++) begin
                settle();
                if (done) n_done++;
                adv();
            end
            chk("abort_no_done", n_done, 0);
            settle();
            chk("abort_irq", irq, v.exp_irq);
            adv();
        end
    endtask

    initial begin
        vt[0] = mk(7'd8,   1, 0, 1, 8'h04, 0, 0, 0, -1, -1, 8'hFB, 0);
        vt[1] = mk(7'd0,   0, 1, 1, 8'h81, 0, 0, 0, -1, -1, 8'h7E, 0);
        vt[2] = mk(7'd5,   1, 1, 0, 8'h10, 1, 0, 0, -1, -1, 8'hEF, 1);
        vt[3] = mk(7'd8,   0, 0, 1, 8'h01, 1, 0, 1,  6, -1, 8'hFE, 1);
        vt[4] = mk(7'd8,   1, 0, 1, 8'h04, 1, 1, 0, -1,  3, 8'hFB, 0);
        vt[5] = mk(7'd1,   0, 1, 1, 8'h80, 0, 0, 0, -1, -1, 8'h7F, 0);
        vt[6] = mk(7'd127, 1, 0, 0, 8'hFF, 0, 0, 0, -1, -1, 8'h00, 0);

        rst_n = 0; go = 0; abort = 0; char_len = 7'd8;
        tx_negedge = 1; rx_negedge = 0; ass = 0; ss_sel = 8'h04;
        ie = 1; irq_clr = 0; cpol_0 = 1; cpol_1 = 1;
        adv();
        adv();
        settle();
        chk("rst_tip", tip, 0);
        chk("rst_lstclk", lstclk, 0);
        chk("rst_shift", shift_en, 0);
        chk("rst_sample", sample_en, 0);
        chk("rst_cnt", bit_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_irq", irq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ss", ss_pad_o, 8'hFF);
        adv();
        ass = 1;
        rst_n = 1;
        settle();
        chk("idle_strobe_shift", shift_en, 0);
        chk("idle_strobe_sample", sample_en, 0);
        adv();
        cpol_0 = 0; cpol_1 = 0;
        settle();
        chk("idle_strobe_cnt", bit_cnt, 0);
        chk("idle_strobe_busy", busy, 0);
        adv();

        for (int i = 0; i < 7; i++) run(vt[i]);

        ass = 1; ss_sel = 8'h04; tx_negedge = 1; rx_negedge = 0;
        ie = 0; char_len = 7'd8; go = 1;
        settle();
        adv();
        go = 0;
        settle();
        adv();
        cpol_1 = 1;
        settle();
        adv();
        settle();
        adv();
        cpol_1 = 0;
        settle();
        chk("pre_rst_cnt", bit_cnt, 6);
        chk("pre_rst_tip", tip, 1);
        adv();
        rst_n = 0;
        settle();
        adv();
        settle();
        chk("midrst_tip", tip, 0);
        chk("midrst_lstclk", lstclk, 0);
        chk("midrst_cnt", bit_cnt, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ss", ss_pad_o, 8'hFF);
        adv();
        rst_n = 1;
        adv();
        run(vt[0]);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
